mix_columns_seq: RTL and testbench
==================================

Name: mix_columns_seq

Overview:
- Sequential AES-128 MixColumns engine; consumes the 128-bit state produced by ShiftRows and feeds AddRoundKey.
- Processes COLS_PER_CYCLE columns per clock using per-byte GF(2^8) xtime multiply-by-2/3 cells.
- Valid/ready handshake on input and output; holds one state in flight.

Parameters:
- COLS_PER_CYCLE, 1, columns computed per CALC cycle; legal values 1, 2, 4. CALC length = 4/COLS_PER_CYCLE cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_state is valid.
- in_ready  out  1  block can accept a state.
- in_state  in  128  byte k = in_state[127-8k -: 8]; column c = bytes 4c..4c+3 (row 0 first), FIPS-197 order.
- out_valid  out  1  out_state holds a completed result.
- out_ready  in  1  downstream accepts out_state.
- out_state  out  128  MixColumns result, same byte order as in_state.

Behaviour:
- Reset: clk and rst_n as stated. Reset is asynchronous and active-low. out_valid=0, out_state=0, FSM=IDLE, column counter=0, working register=0.
- FSM states:
  - IDLE -> CALC on accept, where accept = in_valid & in_ready. in_state is latched into the working register and the counter is cleared.
  - CALC: each cycle computes columns cnt .. cnt+COLS_PER_CYCLE-1 and writes them into the result register. cnt advances by COLS_PER_CYCLE. After the last group, go to DONE.
  - DONE: out_valid=1. out_state is stable until out_valid & out_ready.
- in_ready = (FSM==IDLE) | (FSM==DONE & out_ready).
  - Accept in the same cycle as the output handshake goes directly DONE->CALC (back-to-back).
  - Output handshake with no new accept goes DONE->IDLE.
- Latency: out_valid rises 4/COLS_PER_CYCLE + 1 edges after the accept edge (COLS_PER_CYCLE=1: 5).
- Throughput: one state per 4/COLS_PER_CYCLE + 1 cycles under continuous ready.
- Per-column arithmetic, column a0..a3:
  - b0 = 2a0 ^ 3a1 ^ a2 ^ a3
  - b1 = a0 ^ 2a1 ^ 3a2 ^ a3
  - b2 = a0 ^ a1 ^ 2a2 ^ 3a3
  - b3 = 3a0 ^ a1 ^ a2 ^ 2a3
  - 2x = {x[6:0],0} ^ (x[7] ? 8'h1B : 0); 3x = 2x ^ x. All arithmetic is 8-bit XOR, no carries.
- Counter is 2 bits and wraps naturally. Its value is ignored outside CALC.
- in_state changes while not accepted are ignored. out_valid is never deasserted without a handshake.
- out_ready asserted in IDLE/CALC has no effect.
- rst_n low mid-CALC or in DONE: immediate abort; the in-flight state is discarded and no output is produced.

Optional Feature:
- Macro: MIX_COLUMNS_INV_EN.
- Defined:
  - Adds input port inv_mode (1 bit), latched at accept.
  - When the latched value is 1, each column computes InvMixColumns with coefficients 0e/0b/0d/09, built from chained xtime.
  - Latency and handshake are unchanged.
- Undefined:
  - No inv_mode port.
  - Forward transform only; no inverse logic is synthesised.

Decomposition:
- Package aes_pkg:
  - typedefs aes_byte_t (8), aes_col_t (32), aes_state_t (128).
  - constant AES_POLY_RED = 8'h1B.
  - function xtime.
  - FSM state enum {IDLE, CALC, DONE}.
- Sub-module mix_single_column:
  - Combinational, one 32-bit column in, one 32-bit column out (plus inv_mode under the macro).
  - Instantiated COLS_PER_CYCLE times; the top holds the FSM, counter and registers.

Test Plan:
- Column vectors, COLS_PER_CYCLE=1:
  - db135345 -> 8e4da1bc; f20a225c -> 9fdc589d; c6c6c6c6 -> c6c6c6c6; d4d4d4d5 -> d5d5d7d6.
  - Pack as one state; out_valid exactly 5 edges after accept.
- FIPS-197 round 1: in_state d4bf5d30e0b452aeb84111f11e2798e5 -> out_state 046681e5e0cb199a48f8d37a2806264c.
  - Repeat with COLS_PER_CYCLE=2 (latency 3) and COLS_PER_CYCLE=4 (latency 2).
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - out_state stable, in_ready=0 throughout.
  - Raise out_ready together with in_valid: new state accepted that edge, next result 5 edges later.
- Reset: assert rst_n=0 two cycles after accept.
  - out_valid=0, out_state=0 immediately; in_ready=1 after release; no stale output appears.
- Under MIX_COLUMNS_INV_EN: inv_mode=1, in_state 046681e5e0cb199a48f8d37a2806264c -> d4bf5d30e0b452aeb84111f11e2798e5.
  - inv_mode=0 still yields the forward result.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES byte/column/state types, GF(2^8) xtime and MixColumns FSM states
package aes_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [31:0]  aes_col_t;
  typedef logic [127:0] aes_state_t;

  localparam aes_byte_t AES_POLY_RED = 8'h1B;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mc_state_e;

  function automatic aes_byte_t xtime(input aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_RED : 8'h00);
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// rtl/mix_single_column.sv - combinational MixColumns of one 32-bit column (row 0 in the MSB byte)
// MIX_COLUMNS_INV_EN adds i_inv_mode selecting InvMixColumns.
module mix_single_column
  import aes_pkg::*;
(
  input  aes_col_t i_col,
`ifdef MIX_COLUMNS_INV_EN
  input  logic     i_inv_mode,
`endif
  output aes_col_t o_col
);

  aes_byte_t w_a  [4];
  aes_byte_t w_x2 [4];
  aes_byte_t w_x3 [4];
  aes_col_t  w_fwd;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_a[i]  = i_col[31-8*i -: 8];
      w_x2[i] = xtime(w_a[i]);
      w_x3[i] = w_x2[i] ^ w_a[i];
    end
  end

  assign w_fwd = {w_x2[0] ^ w_x3[1] ^ w_a[2]  ^ w_a[3],
                  w_a[0]  ^ w_x2[1] ^ w_x3[2] ^ w_a[3],
                  w_a[0]  ^ w_a[1]  ^ w_x2[2] ^ w_x3[3],
                  w_x3[0] ^ w_a[1]  ^ w_a[2]  ^ w_x2[3]};

`ifdef MIX_COLUMNS_INV_EN
  aes_byte_t w_x4 [4];
  aes_byte_t w_x8 [4];
  aes_byte_t w_m9 [4];
  aes_byte_t w_mb [4];
  aes_byte_t w_md [4];
  aes_byte_t w_me [4];
  aes_col_t  w_inv;

  // 9/b/d/e multiples built from the x2 -> x4 -> x8 xtime chain
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_x4[i] = xtime(w_x2[i]);
      w_x8[i] = xtime(w_x4[i]);
      w_m9[i] = w_x8[i] ^ w_a[i];
      w_mb[i] = w_x8[i] ^ w_x2[i] ^ w_a[i];
      w_md[i] = w_x8[i] ^ w_x4[i] ^ w_a[i];
      w_me[i] = w_x8[i] ^ w_x4[i] ^ w_x2[i];
    end
  end

  assign w_inv = {w_me[0] ^ w_mb[1] ^ w_md[2] ^ w_m9[3],
                  w_m9[0] ^ w_me[1] ^ w_mb[2] ^ w_md[3],
                  w_md[0] ^ w_m9[1] ^ w_me[2] ^ w_mb[3],
                  w_mb[0] ^ w_md[1] ^ w_m9[2] ^ w_me[3]};

  assign o_col = i_inv_mode ? w_inv : w_fwd;
`else
  assign o_col = w_fwd;
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - sequential AES MixColumns, COLS_PER_CYCLE columns per CALC cycle, valid/ready both sides
// MIX_COLUMNS_INV_EN adds inv_mode (latched at accept) for InvMixColumns.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         inv_mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  mc_state_e  r_state;
  mc_state_e  w_next;
  logic [1:0] r_cnt;
  aes_col_t   r_work   [4];
  aes_col_t   r_result [4];
  logic       r_inv;
  logic       w_accept;

  aes_col_t   w_col_in  [COLS_PER_CYCLE];
  aes_col_t   w_col_out [COLS_PER_CYCLE];
  logic [1:0] w_idx     [COLS_PER_CYCLE];

  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid & in_ready;
  assign out_state = {r_result[0], r_result[1], r_result[2], r_result[3]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (r_cnt == LAST_CNT) w_next = DONE;
      DONE: begin
        if (w_accept)       w_next = CALC;
        else if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Column lanes: lane g works on column r_cnt+g (2-bit wrap)
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign w_idx[g]    = r_cnt + 2'(g);
    assign w_col_in[g] = r_work[w_idx[g]];

    mix_single_column u_col (
      .i_col      (w_col_in[g]),
`ifdef MIX_COLUMNS_INV_EN
      .i_inv_mode (r_inv),
`endif
      .o_col      (w_col_out[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_inv <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_work[k]   <= '0;
        r_result[k] <= '0;
      end
    end else if (w_accept) begin
      r_cnt <= '0;
`ifdef MIX_COLUMNS_INV_EN
      r_inv <= inv_mode;
`else
      r_inv <= 1'b0;
`endif
      for (int k = 0; k < 4; k++) r_work[k] <= in_state[127-32*k -: 32];
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + CNT_STEP;
      for (int g = 0; g < COLS_PER_CYCLE; g++) r_result[w_idx[g]] <= w_col_out[g];
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - randomized self-checking bench for mix_columns_seq at COLS_PER_CYCLE 1, 2 and 4
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid_a  [3];
  logic         in_ready_a  [3];
  logic         out_valid_a [3];
  logic         out_ready_a [3];
  logic [127:0] in_state_a  [3];
  logic [127:0] out_state_a [3];
`ifdef MIX_COLUMNS_INV_EN
  logic         inv_mode_a  [3];
`endif

  int n_checks = 0;
  int n_errors = 0;
  int lat_tab [3] = '{5, 3, 2};

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_state(in_state_a[0]),
`ifdef MIX_COLUMNS_INV_EN
    .inv_mode(inv_mode_a[0]),
`endif
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_state(out_state_a[0]));

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_state(in_state_a[1]),
`ifdef MIX_COLUMNS_INV_EN
    .inv_mode(inv_mode_a[1]),
`endif
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_state(out_state_a[1]));

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .in_state(in_state_a[2]),
`ifdef MIX_COLUMNS_INV_EN
    .inv_mode(inv_mode_a[2]),
`endif
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_state(out_state_a[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Generic GF(2^8) product by shift-and-add, independent of any xtime chaining
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product per column: out[r] = XOR_j coef[(j-r) mod 4] * a[j]
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   b;
    logic [127:0] r = '0;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-32*c-8*j -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(coef[(j - rr + 4) % 4], a[j]);
        r[127-32*c-8*rr -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accept edge counts as edge 1; latency is the edge after which out_valid is seen high
  task automatic xfer(input int d, input logic [127:0] st, input bit inv,
                      input logic [127:0] exp, input string tag);
    int n;
    @(negedge clk);
    chk({tag, "_in_ready"}, 128'(in_ready_a[d]), 128'(1));
    in_state_a[d]  = st;
    in_valid_a[d]  = 1'b1;
    out_ready_a[d] = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
    inv_mode_a[d]  = inv;
`endif
    @(posedge clk); #1;
    in_valid_a[d] = 1'b0;
    in_state_a[d] = rnd128();
`ifdef MIX_COLUMNS_INV_EN
    inv_mode_a[d] = ~inv;
`endif
    n = 1;
    while (!out_valid_a[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(lat_tab[d]));
    chk({tag, "_out"}, out_state_a[d], exp);
    @(posedge clk); #1;
    chk({tag, "_valid_clr"}, 128'(out_valid_a[d]), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] s, s2, exp_hold;
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid_a[d] = 1'b0; out_ready_a[d] = 1'b0; in_state_a[d] = '0;
`ifdef MIX_COLUMNS_INV_EN
      inv_mode_a[d] = 1'b0;
`endif
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_out_valid%0d", d), 128'(out_valid_a[d]), 128'(0));
      chk($sformatf("rst_out_state%0d", d), out_state_a[d], 128'(0));
      chk($sformatf("rst_in_ready%0d", d), 128'(in_ready_a[d]), 128'(1));
    end

    xfer(0, 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5, 1'b0,
         128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6, "colvec");
    for (int d = 0; d < 3; d++)
      xfer(d, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
           128'h046681e5e0cb199a48f8d37a2806264c, $sformatf("fips%0d", d));
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 6; i++) begin
        s = rnd128();
        xfer(d, s, 1'b0, ref_mix(s, 1'b0), $sformatf("rnd%0d_%0d", d, i));
      end

    // Backpressure in DONE, then release together with a new accept
    s = rnd128();
    s2 = rnd128();
    exp_hold = ref_mix(s, 1'b0);
    @(negedge clk);
    in_state_a[0] = s; in_valid_a[0] = 1'b1; out_ready_a[0] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    n = 0;
    while (!out_valid_a[0] && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_reach_done", 128'(out_valid_a[0]), 128'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_state_a[0] = rnd128();
      chk("bp_hold_state", out_state_a[0], exp_hold);
      chk("bp_hold_valid", 128'(out_valid_a[0]), 128'(1));
      chk("bp_in_ready", 128'(in_ready_a[0]), 128'(0));
    end
    @(negedge clk);
    in_state_a[0] = s2; in_valid_a[0] = 1'b1; out_ready_a[0] = 1'b1;
    #1 chk("b2b_in_ready", 128'(in_ready_a[0]), 128'(1));
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    n = 1;
    while (!out_valid_a[0] && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b_latency", 128'(n), 128'(5));
    chk("b2b_out", out_state_a[0], ref_mix(s2, 1'b0));
    @(posedge clk); #1;
    chk("b2b_valid_clr", 128'(out_valid_a[0]), 128'(0));

    // Abort mid-CALC
    @(negedge clk);
    in_state_a[0] = rnd128(); in_valid_a[0] = 1'b1; out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 128'(out_valid_a[0]), 128'(0));
    chk("abort_out_state", out_state_a[0], 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort_in_ready", 128'(in_ready_a[0]), 128'(1));
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid_a[0]) n++;
    end
    chk("abort_no_stale", 128'(n), 128'(0));
    xfer(0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
         128'h046681e5e0cb199a48f8d37a2806264c, "post_abort");

`ifdef MIX_COLUMNS_INV_EN
    for (int d = 0; d < 3; d++)
      xfer(d, 128'h046681e5e0cb199a48f8d37a2806264c, 1'b1,
           128'hd4bf5d30e0b452aeb84111f11e2798e5, $sformatf("inv%0d", d));
    for (int i = 0; i < 6; i++) begin
      s = rnd128();
      xfer(i % 3, s, i[0], ref_mix(s, i[0]), $sformatf("rndinv%0d", i));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
